cas4_frame_sorter: RTL and testbench



---
 rtl/cas4_frame_sorter_pkg.sv | 19 +
 rtl/cas4_frame_sorter_cas4.sv | 37 +++
 rtl/cas4_frame_sorter.sv | 126 ++++++++++++
 tb/tb_cas4_frame_sorter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas4_frame_sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cas4_frame_sorter_pkg
// Description : Shared constants and FSM state type for the cas4 frame sorter.
// Revision    : 1.0 - initial release
// ============================================================================
package cas4_frame_sorter_pkg;

    localparam int NUM_INPUTS = 4;
    localparam int DEF_BITS   = 6;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage : cas4_frame_sorter_pkg
`default_nettype wire

// File: rtl/cas4_frame_sorter_cas4.sv
`default_nettype none
// ============================================================================
// Module      : cas4_frame_sorter_cas4
// Description : Combinational 4-input compare-and-swap network, largest on a_new.
// Revision    : 1.0 - initial release
// ============================================================================
module cas4_frame_sorter_cas4
    import cas4_frame_sorter_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] c,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] a_new,
    output logic [BITS-1:0] b_new,
    output logic [BITS-1:0] c_new,
    output logic [BITS-1:0] d_new
);

    logic [BITS-1:0] w_hi0, w_lo0, w_hi1, w_lo1, w_mid_hi, w_mid_lo;

    // Five-comparator network: pairs, then extremes, then the middle pair.
    assign w_hi0    = (a >= b) ? a : b;
    assign w_lo0    = (a >= b) ? b : a;
    assign w_hi1    = (c >= d) ? c : d;
    assign w_lo1    = (c >= d) ? d : c;
    assign a_new    = (w_hi0 >= w_hi1) ? w_hi0 : w_hi1;
    assign w_mid_hi = (w_hi0 >= w_hi1) ? w_hi1 : w_hi0;
    assign w_mid_lo = (w_lo0 >= w_lo1) ? w_lo0 : w_lo1;
    assign d_new    = (w_lo0 >= w_lo1) ? w_lo1 : w_lo0;
    assign b_new    = (w_mid_hi >= w_mid_lo) ? w_mid_hi : w_mid_lo;
    assign c_new    = (w_mid_hi >= w_mid_lo) ? w_mid_lo : w_mid_hi;

endmodule : cas4_frame_sorter_cas4
`default_nettype wire

// File: rtl/cas4_frame_sorter.sv
`default_nettype none
// ============================================================================
// Module      : cas4_frame_sorter
// Description : Valid/ready serial front/back end around the cas4 sorter.
// Revision    : 1.0 - initial release
// ============================================================================
module cas4_frame_sorter
    import cas4_frame_sorter_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter bit DESC = 1'b1,
    parameter int FCW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last,
    output logic [FCW-1:0]  frame_cnt,
    output logic            sort_err
);

    state_e          state_q, state_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [BITS-1:0] slot_q   [NUM_INPUTS];
    logic [BITS-1:0] slot_d   [NUM_INPUTS];
    logic [BITS-1:0] sorted_q [NUM_INPUTS];
    logic [BITS-1:0] sorted_d [NUM_INPUTS];
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
    logic            sort_err_q, sort_err_d;

    logic [BITS-1:0] w_a_new, w_b_new, w_c_new, w_d_new;
    logic            w_mono;
    logic [1:0]      w_rd_idx;

    cas4_frame_sorter_cas4 #(.BITS(BITS)) u_cas4 (
        .a     (slot_q[0]),
        .b     (slot_q[1]),
        .c     (slot_q[2]),
        .d     (slot_q[3]),
        .a_new (w_a_new),
        .b_new (w_b_new),
        .c_new (w_c_new),
        .d_new (w_d_new)
    );

    assign w_mono   = (w_a_new >= w_b_new) && (w_b_new >= w_c_new) && (w_c_new >= w_d_new);
    assign w_rd_idx = DESC ? rd_ptr_q : (2'd3 - rd_ptr_q);

    assign in_ready  = (state_q == ST_FILL) && !rst;
    assign out_valid = (state_q == ST_DRAIN) && !rst;
    assign out_last  = out_valid && (rd_ptr_q == 2'd3);
    assign out_data  = rst ? '0 : sorted_q[w_rd_idx];
    assign frame_cnt = frame_cnt_q;
    assign sort_err  = sort_err_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        slot_d      = slot_q;
        sorted_d    = sorted_q;
        frame_cnt_d = frame_cnt_q;
        sort_err_d  = sort_err_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready) begin
                    slot_d[wr_ptr_q] = in_data;
                    wr_ptr_d         = wr_ptr_q + 2'd1;
                    if (wr_ptr_q == 2'd3) begin
                        state_d = ST_SORT;
                    end
                end
            end
            ST_SORT: begin
                sorted_d[0] = w_a_new;
                sorted_d[1] = w_b_new;
                sorted_d[2] = w_c_new;
                sorted_d[3] = w_d_new;
                if (!w_mono) begin
                    sort_err_d = 1'b1;
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    rd_ptr_d = rd_ptr_q + 2'd1;
                    if (rd_ptr_q == 2'd3) begin
                        frame_cnt_d = frame_cnt_q + {{(FCW-1){1'b0}}, 1'b1};
                        state_d     = ST_FILL;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            slot_q      <= '{default: '0};
            sorted_q    <= '{default: '0};
            frame_cnt_q <= '0;
            sort_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            slot_q      <= slot_d;
            sorted_q    <= sorted_d;
            frame_cnt_q <= frame_cnt_d;
            sort_err_q  <= sort_err_d;
        end
    end

endmodule : cas4_frame_sorter
`default_nettype wire

// File: tb/tb_cas4_frame_sorter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cas4_frame_sorter
// Description : Two sorter instances (descending/16-bit count, ascending/2-bit
//               count) fed by shared stimulus and checked against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cas4_frame_sorter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last, a_sort_err;
    logic [5:0]  a_out_data;
    logic [15:0] a_frame_cnt;
    logic        b_in_ready, b_out_valid, b_out_last, b_sort_err;
    logic [5:0]  b_out_data;
    logic [1:0]  b_frame_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cas4_frame_sorter #(.BITS(6), .DESC(1'b1), .FCW(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .frame_cnt(a_frame_cnt),
        .sort_err(a_sort_err)
    );

    cas4_frame_sorter #(.BITS(6), .DESC(1'b0), .FCW(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .frame_cnt(b_frame_cnt),
        .sort_err(b_sort_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Frame-level model: samples collected, pending sorted outputs, frame counts.
    logic [5:0] col[$];
    logic [5:0] q_desc[$];
    logic [5:0] q_asc[$];
    int         fc_a = 0;
    int         fc_b = 0;
    bit         live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            col.delete(); q_desc.delete(); q_asc.delete();
            fc_a = 0; fc_b = 0; live = 1'b1;
        end else if (q_desc.size() > 0) begin
            if (out_ready) begin
                void'(q_desc.pop_front());
                void'(q_asc.pop_front());
                if (q_desc.size() == 0) begin
                    fc_a = (fc_a + 1) % 65536;
                    fc_b = (fc_b + 1) % 4;
                end
            end
        end else if (col.size() == 4) begin
            logic [5:0] s [4];
            logic [5:0] t;
            for (int i = 0; i < 4; i++) s[i] = col[i];
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
            for (int i = 0; i < 4; i++) begin
                q_asc.push_back(s[i]);
                q_desc.push_back(s[3-i]);
            end
            col.delete();
        end else if (in_valid) begin
            col.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            logic exp_rdy, exp_vld;
            exp_rdy = !rst && (q_desc.size() == 0) && (col.size() < 4);
            exp_vld = !rst && (q_desc.size() > 0);
            chk("a_in_ready", a_in_ready, exp_rdy);
            chk("b_in_ready", b_in_ready, exp_rdy);
            chk("a_out_valid", a_out_valid, exp_vld);
            chk("b_out_valid", b_out_valid, exp_vld);
            chk("a_out_last", a_out_last, exp_vld && (q_desc.size() == 1));
            chk("b_out_last", b_out_last, exp_vld && (q_asc.size() == 1));
            if (exp_vld) begin
                chk("a_out_data", a_out_data, q_desc[0]);
                chk("b_out_data", b_out_data, q_asc[0]);
            end
            if (rst) begin
                chk("a_out_data_rst", a_out_data, 0);
                chk("b_out_data_rst", b_out_data, 0);
            end
            chk("a_frame_cnt", a_frame_cnt, fc_a);
            chk("b_frame_cnt", b_frame_cnt, fc_b);
            chk("a_sort_err", a_sort_err, 0);
            chk("b_sort_err", b_sort_err, 0);
        end
    end

    // Delivered samples, for hand-computed frame expectations.
    logic [5:0] cap_a[$];
    logic [5:0] cap_b[$];
    always @(posedge clk) begin
        if (!rst && a_out_valid && out_ready) cap_a.push_back(a_out_data);
        if (!rst && b_out_valid && out_ready) cap_b.push_back(b_out_data);
    end

    int   rdy_mode = 0;
    int   pat_i    = 0;
    logic pat [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    if (pat_i < 7) begin
                        out_ready = pat[pat_i];
                        if (a_out_valid) pat_i++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [5:0] d, input bit keep);
        int n   = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 100) begin
            @(posedge clk);
            acc = a_in_ready;
            n++;
        end
        #1;
        if (!keep) in_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (a_frame_cnt != 16'(target) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("wait_frames", a_frame_cnt, target);
    endtask

    task automatic check_frame(input string nm, input logic [5:0] cap[$], input int off,
                               input logic [5:0] e0, input logic [5:0] e1,
                               input logic [5:0] e2, input logic [5:0] e3);
        logic [5:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, (cap.size() >= off + 4), 1);
        if (cap.size() >= off + 4) begin
            for (int i = 0; i < 4; i++) chk(nm, cap[off+i], e[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_frame_cnt", a_frame_cnt, 0);
        chk("rst_out_data", a_out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Partial frame discarded by a mid-fill reset.
        send(6'd1, 1'b0);
        send(6'd2, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", a_in_ready, 0);
        chk("midrst_out_valid", b_out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        cap_a.delete(); cap_b.delete();
        send(6'd5, 1'b0); send(6'd63, 1'b0); send(6'd0, 1'b0); send(6'd17, 1'b0);
        @(negedge clk);
        chk("sort_cycle_valid", a_out_valid, 0);
        @(negedge clk);
        chk("latency_valid", a_out_valid, 1);
        chk("first_out", a_out_data, 63);
        wait_frames(1);
        check_frame("t2_desc", cap_a, 0, 6'd63, 6'd17, 6'd5, 6'd0);
        check_frame("t2_asc", cap_b, 0, 6'd0, 6'd5, 6'd17, 6'd63);
        chk("t2_frame_cnt", a_frame_cnt, 1);

        cap_a.delete(); cap_b.delete();
        send(6'd9, 1'b0); send(6'd9, 1'b0); send(6'd40, 1'b0); send(6'd9, 1'b0);
        wait_frames(2);
        check_frame("t3_desc", cap_a, 0, 6'd40, 6'd9, 6'd9, 6'd9);
        check_frame("t3_asc", cap_b, 0, 6'd9, 6'd9, 6'd9, 6'd40);
        chk("t3_sort_err", b_sort_err, 0);

        cap_a.delete(); cap_b.delete();
        pat_i = 0; rdy_mode = 1;
        send(6'd3, 1'b0); send(6'd1, 1'b0); send(6'd4, 1'b0); send(6'd2, 1'b0);
        wait_frames(3);
        check_frame("t4_desc", cap_a, 0, 6'd4, 6'd3, 6'd2, 6'd1);
        chk("t4_exact_once", cap_a.size(), 4);
        rdy_mode = 0;

        cap_a.delete(); cap_b.delete();
        send(6'd10, 1'b1); send(6'd20, 1'b1); send(6'd30, 1'b1); send(6'd40, 1'b1);
        send(6'd7, 1'b1);  send(6'd7, 1'b1);  send(6'd1, 1'b1);  send(6'd63, 1'b0);
        wait_frames(5);
        check_frame("t5_f1", cap_a, 0, 6'd40, 6'd30, 6'd20, 6'd10);
        check_frame("t5_f2", cap_a, 4, 6'd63, 6'd7, 6'd7, 6'd1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(6'($urandom_range(0, 63)), 1'b0);
        end
        wait_frames(5);
        chk("t6_b_wrap", b_frame_cnt, 1);
        chk("t6_sort_err", b_sort_err, 0);
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_cas4_frame_sorter
`default_nettype wire
